ysyx_22041752_mmio_master: RTL and testbench
============================================

Name: ysyx_22041752_mmio_master

Overview:
Initiator side of the core's memory-mapped device port. It accepts one load or store from the LSU over a valid/ready request channel and drives the device-side en/wen/addr/wdata strobes, which the CLINT and similar registered responders sample. It waits for the responder's one-cycle rdat_v, extracts and extends sub-word load data, and returns a single-cycle response to the LSU. Timeout, misalignment and unsupported-size conditions are reported as access errors.

Parameters:
TIMEOUT, 16, maximum cycles spent in WAIT for rdat_v before the load is declared an error (must be ≥2)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  1  LSU request valid
req_ready  out  1  block can accept a request
req_wen  in  1  1=store, 0=load
req_addr  in  64  byte address
req_wdata  in  64  store data, doubleword
req_size  in  2  0=byte 1=half 2=word 3=doubleword
req_unsigned  in  1  zero-extend load result when 1, sign-extend when 0
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  64  extended load data (0 for stores and errors)
resp_err  out  1  access fault, qualified by resp_valid
en  out  1  device access strobe
wen  out  1  device write strobe
addr  out  64  device address, 8-byte aligned
wdata  out  64  device write data
rdata  in  64  device read data
rdat_v  in  1  device read-data valid, one cycle after en

Behaviour:
- Single clock; all state is cleared asynchronously while reset=0. Under reset: state=IDLE, en=0, wen=0, addr=0, wdata=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1.
- States: IDLE, ISSUE, WAIT, RESP. req_ready = (state==IDLE).
- IDLE: on req_valid, latch wen/addr/wdata/size/unsigned.
  - If the access is misaligned, or is a store with req_size≠3, go to RESP with err=1. No device strobe is issued.
  - Otherwise go to ISSUE.
  - Misaligned means: size1 with addr[0]≠0, size2 with addr[1:0]≠0, size3 with addr[2:0]≠0.
- ISSUE (exactly 1 cycle):
  - en=1; wen=latched wen; addr={latched addr[63:3],3'b000}; wdata=latched wdata.
  - Store: go to RESP, err=0.
  - Load: go to WAIT with the timeout counter cleared.
- en and wen are 0 in every state except ISSUE. addr and wdata hold their last value outside ISSUE.
- WAIT:
  - rdat_v=1: capture rdata and go to RESP, err=0.
  - Otherwise increment the counter. If the counter reaches TIMEOUT-1 with no rdat_v, go to RESP with err=1.
  - WAIT lasts at most TIMEOUT cycles.
  - If rdat_v arrives in the final WAIT cycle, the data wins and no error is raised.
- Load extraction (in the cycle rdat_v is captured), with offset=addr[2:0]:
  - byte = rdata[8*offset +: 8]
  - half = rdata[8*offset +: 16]
  - word = rdata[8*offset +: 32]
  - doubleword = rdata
  - Result is sign- or zero-extended to 64 bits per req_unsigned.
- RESP (exactly 1 cycle): resp_valid=1 with registered resp_rdata/resp_err; next state is IDLE.
  - The LSU cannot stall the response.
  - resp_rdata=0 for stores and errors.
  - resp_valid=0 in all other states.
- rdat_v outside WAIT is ignored; it causes no state change and no data capture.
- req_valid outside IDLE is not accepted (req_ready=0); the LSU holds its request.
- Latency, counting the acceptance edge as cycle 0:
  - store: RESP in cycle 2
  - load with rdat_v in the cycle after ISSUE: RESP in cycle 3
  - early error: RESP in cycle 1
  - timeout: RESP in cycle 2+TIMEOUT
- Back-to-back: a new request can be accepted in the first IDLE cycle after RESP, so the minimum spacing between stores is 3 cycles.
- Reset asserted mid-transaction aborts it: no response is produced, and en drops immediately.

Test Plan:
- Store doubleword, addr=0x0200_4000, wdata=0x1234 → one cycle with en=1, wen=1, addr=0x0200_4000, wdata=0x1234; resp_valid in cycle 2 with err=0, rdata=0.
- Load doubleword, addr=0x0200_BFF8; model returns rdat_v=1, rdata=0xAABB_CCDD_8899_0011 one cycle after en → resp_rdata=0xAABB_CCDD_8899_0011, err=0, resp in cycle 3, wen=0 throughout.
- Word load with addr[2:0]=4, rdata=0x8000_0001_0000_0000, sign-extended → 0xFFFF_FFFF_8000_0001. Same access with req_unsigned=1 → 0x0000_0000_8000_0001. Byte load at offset 7 of 0xFF00…00, signed → 0xFFFF_FFFF_FFFF_FFFF.
- Load from an unmapped address (model never asserts rdat_v), TIMEOUT=16 → en pulses once; resp_err=1, rdata=0 at cycle 18; req_ready returns to 1 the next cycle. Repeat with rdat_v delivered in the last WAIT cycle → err=0 with the data returned.
- Half load at addr 0x…01, and word store (size=2) → resp_err=1 at cycle 1 and en never asserted. A stray rdat_v pulse while IDLE → no resp_valid.
- Drop reset to 0 during WAIT → all outputs return to their reset values immediately. After reset is released, a fresh load completes normally with no stale response.

Source files
------------

// File: rtl/ysyx_22041752_mmio_master_if.sv
// rtl/ysyx_22041752_mmio_master_if.sv - LSU request/response and device strobe bundle
interface ysyx_22041752_mmio_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        en;
  logic        wen;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        rdat_v;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, rdata, rdat_v,
    output req_ready, resp_valid, resp_rdata, resp_err, en, wen, addr, wdata
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned, rdata, rdat_v,
    input  req_ready, resp_valid, resp_rdata, resp_err, en, wen, addr, wdata
  );
endinterface

// File: rtl/ysyx_22041752_mmio_master.sv
// rtl/ysyx_22041752_mmio_master.sv - single-outstanding MMIO initiator for the LSU device port
module ysyx_22041752_mmio_master #(
  parameter int TIMEOUT = 16
) (
  input logic                          clk,
  input logic                          reset,
  ysyx_22041752_mmio_master_if.master  bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_nxt;
  logic [63:0]   rdata_nxt;

  logic          lat_wen;
  logic [2:0]    lat_off;
  logic [1:0]    lat_size;
  logic          lat_unsigned;

  logic          misaligned;
  logic [63:0]   shifted;
  logic [63:0]   load_ext;

  assign bus.req_ready = (state == IDLE);

  // Alignment is judged on the incoming request so early errors never touch the device.
  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'd1:    misaligned = bus.req_addr[0];
      2'd2:    misaligned = |bus.req_addr[1:0];
      2'd3:    misaligned = |bus.req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Lane select and sign/zero extension of the returned doubleword.
  always_comb begin
    shifted  = bus.rdata >> {lat_off, 3'b000};
    load_ext = shifted;
    case (lat_size)
      2'd0: load_ext = lat_unsigned ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1: load_ext = lat_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_ext = lat_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // Next-state, timeout counter and response payload for the cycle entering RESP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    rdata_nxt = 64'd0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (misaligned || (bus.req_wen && bus.req_size != 2'd3)) begin
            state_nxt = RESP;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = lat_wen ? RESP : WAIT;
      end
      WAIT: begin
        if (bus.rdat_v) begin
          state_nxt = RESP;
          rdata_nxt = load_ext;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt = RESP;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request attributes captured at acceptance for use during WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_wen      <= 1'b0;
      lat_off      <= 3'd0;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
    end else if (state == IDLE && bus.req_valid) begin
      lat_wen      <= bus.req_wen;
      lat_off      <= bus.req_addr[2:0];
      lat_size     <= bus.req_size;
      lat_unsigned <= bus.req_unsigned;
    end
  end

  // Registered device strobes and LSU response; addr/wdata hold outside ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.en         <= 1'b0;
      bus.wen        <= 1'b0;
      bus.addr       <= 64'd0;
      bus.wdata      <= 64'd0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= 64'd0;
    end else begin
      bus.en         <= (state_nxt == ISSUE);
      bus.wen        <= (state_nxt == ISSUE) && bus.req_wen;
      if (state_nxt == ISSUE) begin
        bus.addr  <= {bus.req_addr[63:3], 3'b000};
        bus.wdata <= bus.req_wdata;
      end
      bus.resp_valid <= (state_nxt == RESP);
      bus.resp_err   <= err_nxt;
      bus.resp_rdata <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_mmio_master.sv
// tb/tb_ysyx_22041752_mmio_master.sv - directed vector bench for the MMIO initiator
module tb_ysyx_22041752_mmio_master;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ysyx_22041752_mmio_master_if bus();

  ysyx_22041752_mmio_master #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] dev_data;
    int          dly;
    int          exp_lat;
    logic        exp_err;
    logic [63:0] exp_rd;
    int          exp_en;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          lat = -1;
    int          en_cnt = 0;
    int          en_cyc = -100;
    logic        wen_seen = 1'b0;
    logic [63:0] seen_addr = 64'd0;
    logic [63:0] seen_wdata = 64'd0;
    logic [63:0] got_rd = 64'd0;
    logic        got_err = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d ready_before", idx), {63'd0, bus.req_ready}, 64'd1);
    bus.req_valid    = 1'b1;
    bus.req_wen      = v.wen;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int cyc = 1; cyc < 40; cyc++) begin
      if (bus.en) begin
        en_cnt++;
        en_cyc     = cyc;
        seen_addr  = bus.addr;
        seen_wdata = bus.wdata;
      end
      if (bus.wen) wen_seen = 1'b1;
      if (bus.resp_valid) begin
        lat     = cyc;
        got_err = bus.resp_err;
        got_rd  = bus.resp_rdata;
        break;
      end
      if (v.dly >= 0 && cyc == en_cyc + v.dly) begin
        bus.rdat_v = 1'b1;
        bus.rdata  = v.dev_data;
      end else begin
        bus.rdat_v = 1'b0;
        bus.rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      @(negedge clk);
    end
    bus.rdat_v = 1'b0;
    chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("v%0d resp_err", idx), {63'd0, got_err}, {63'd0, v.exp_err});
    chk($sformatf("v%0d resp_rdata", idx), got_rd, v.exp_rd);
    chk($sformatf("v%0d en_pulses", idx), 64'(en_cnt), 64'(v.exp_en));
    chk($sformatf("v%0d wen_seen", idx), {63'd0, wen_seen}, {63'd0, v.wen && (v.exp_en != 0)});
    if (v.exp_en != 0) begin
      chk($sformatf("v%0d dev_addr", idx), seen_addr, v.addr & ~64'h7);
      if (v.wen) chk($sformatf("v%0d dev_wdata", idx), seen_wdata, v.wdata);
    end
    @(negedge clk);
    chk($sformatf("v%0d ready_after", idx), {63'd0, bus.req_ready}, 64'd1);
    chk($sformatf("v%0d single_pulse", idx), {63'd0, bus.resp_valid}, 64'd0);
  endtask

  initial begin
    //            wen  addr                    wdata        sz  uns dev_data                 dly lat err exp_rd                   en
    vecs[0]  = '{1'b1, 64'h0000_0000_0200_4000, 64'h1234,   2'd3, 1'b0, 64'h0,                    -1,  2, 1'b0, 64'h0,                    1};
    vecs[1]  = '{1'b0, 64'h0000_0000_0200_BFF8, 64'h0,      2'd3, 1'b0, 64'hAABB_CCDD_8899_0011,   1,  3, 1'b0, 64'hAABB_CCDD_8899_0011,   1};
    vecs[2]  = '{1'b0, 64'h0000_0000_0200_0004, 64'h0,      2'd2, 1'b0, 64'h8000_0001_0000_0000,   1,  3, 1'b0, 64'hFFFF_FFFF_8000_0001,   1};
    vecs[3]  = '{1'b0, 64'h0000_0000_0200_0004, 64'h0,      2'd2, 1'b1, 64'h8000_0001_0000_0000,   1,  3, 1'b0, 64'h0000_0000_8000_0001,   1};
    vecs[4]  = '{1'b0, 64'h0000_0000_0200_0007, 64'h0,      2'd0, 1'b0, 64'hFF00_0000_0000_0000,   1,  3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,   1};
    vecs[5]  = '{1'b0, 64'h0000_0000_0300_0000, 64'h0,      2'd3, 1'b0, 64'h0,                    -1, 18, 1'b1, 64'h0,                    1};
    vecs[6]  = '{1'b0, 64'h0000_0000_0300_0000, 64'h0,      2'd3, 1'b0, 64'h1122_3344_5566_7788,  16, 18, 1'b0, 64'h1122_3344_5566_7788,   1};
    vecs[7]  = '{1'b0, 64'h0000_0000_0200_0001, 64'h0,      2'd1, 1'b0, 64'h0,                     1,  1, 1'b1, 64'h0,                    0};
    vecs[8]  = '{1'b1, 64'h0000_0000_0200_4000, 64'h55AA,   2'd2, 1'b0, 64'h0,                    -1,  1, 1'b1, 64'h0,                    0};
    vecs[9]  = '{1'b0, 64'h0000_0000_0200_0006, 64'h0,      2'd1, 1'b1, 64'h8765_0000_0000_0000,   1,  3, 1'b0, 64'h0000_0000_0000_8765,   1};
    vecs[10] = '{1'b0, 64'h0000_0000_0200_0006, 64'h0,      2'd1, 1'b0, 64'h8765_0000_0000_0000,   1,  3, 1'b0, 64'hFFFF_FFFF_FFFF_8765,   1};
    vecs[11] = '{1'b0, 64'h0000_0000_0200_0002, 64'h0,      2'd0, 1'b1, 64'h0000_0000_00AB_0000,   3,  5, 1'b0, 64'h0000_0000_0000_00AB,   1};
    vecs[12] = '{1'b0, 64'h0000_0000_0200_0004, 64'h0,      2'd3, 1'b0, 64'h0,                     1,  1, 1'b1, 64'h0,                    0};

    bus.req_valid    = 1'b0;
    bus.req_wen      = 1'b0;
    bus.req_addr     = 64'd0;
    bus.req_wdata    = 64'd0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.rdata        = 64'd0;
    bus.rdat_v       = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst en", {63'd0, bus.en}, 64'd0);
    chk("rst wen", {63'd0, bus.wen}, 64'd0);
    chk("rst addr", bus.addr, 64'd0);
    chk("rst wdata", bus.wdata, 64'd0);
    chk("rst resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst resp_err", {63'd0, bus.resp_err}, 64'd0);
    chk("rst req_ready", {63'd0, bus.req_ready}, 64'd1);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Stray rdat_v while idle must not produce a response.
    @(negedge clk);
    bus.rdat_v = 1'b1;
    bus.rdata  = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    bus.rdat_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stray resp_valid c%0d", k), {63'd0, bus.resp_valid}, 64'd0);
      chk($sformatf("stray ready c%0d", k), {63'd0, bus.req_ready}, 64'd1);
      @(negedge clk);
    end

    // Reset during WAIT aborts the load and clears outputs asynchronously.
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b0;
    bus.req_addr  = 64'h0000_0000_0300_0010;
    bus.req_wdata = 64'h5555_0000_5555_0000;
    bus.req_size  = 2'd3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort issue en", {63'd0, bus.en}, 64'd1);
    chk("abort issue addr", bus.addr, 64'h0000_0000_0300_0010);
    @(negedge clk);
    @(negedge clk);
    chk("abort in wait ready", {63'd0, bus.req_ready}, 64'd0);
    #2 reset = 1'b0;
    #1;
    chk("abort en", {63'd0, bus.en}, 64'd0);
    chk("abort addr", bus.addr, 64'd0);
    chk("abort wdata", bus.wdata, 64'd0);
    chk("abort resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("abort req_ready", {63'd0, bus.req_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    run_vec(vecs[1], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
